zbt_pixel_reader: RTL

- Read-side counterpart of the NTSC-to-ZBT capture path.
- Fetches packed RGB666 pixel pairs from ZBT with a fixed read latency and prefetches ahead of the XGA raster.
- Unpacks each pair and expands it to 24-bit RGB for the VGA output stage.
- Delays sync and blank to match the pixel pipeline, and marks the cycles where the capture writer may own the ZBT port.

---
 rtl/zbt_pixel_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/zbt_pixel_reader.sv
// Read side of the ZBT frame buffer: prefetches packed RGB666 pixel pairs ahead of
// the XGA raster and delivers 24-bit RGB with sync/blank on a 2-cycle pipeline.
module zbt_pixel_reader #(
    parameter int LATENCY = 2,
    parameter int H_TOTAL = 1344,
    parameter int V_TOTAL = 806,
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    output logic [18:0] vram_addr,
    input  logic [35:0] vram_read_data,
    output logic        vram_write_ok,
    output logic [23:0] pixel_rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    function automatic logic [7:0] expand6(input logic [5:0] c6);
        return {c6, c6[5:4]};
    endfunction

    function automatic logic [23:0] rgb666_to_888(input logic [17:0] p);
        return {expand6(p[17:12]), expand6(p[11:6]), expand6(p[5:0])};
    endfunction

    logic [11:0]        t_sum_s;
    logic [11:0]        t_col_s;
    logic [9:0]         t_row_s;
    logic               t_valid_s;
    logic [18:0]        addr_r;
    logic [LATENCY:0]   rd_pipe_r;
    logic [LATENCY:0]   vld_pipe_r;
    logic [35:0]        word_r;
    logic               word_vld_r;
    logic               hc0_d1_r;
    logic               hsync_d1_r;
    logic               vsync_d1_r;
    logic               blank_d1_r;
    logic [17:0]        pix_sel_s;
    logic [23:0]        pix_next_s;
    logic [23:0]        pixel_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               blank_r;

    // Prefetch target column/row for a read issued this cycle, wrapping line and frame.
    always_comb begin
        t_sum_s = {1'b0, hcount} + 12'(1 + LATENCY);
        t_col_s = t_sum_s;
        t_row_s = vcount;
        if (t_sum_s >= 12'(H_TOTAL)) begin
            t_col_s = t_sum_s - 12'(H_TOTAL);
            if ({1'b0, vcount} >= 11'(V_TOTAL - 1)) begin
                t_row_s = 10'd0;
            end else begin
                t_row_s = vcount + 10'd1;
            end
        end else begin
            t_col_s = t_sum_s;
        end
        t_valid_s = (t_col_s < 12'(IMG_W)) && ({1'b0, t_row_s} < 11'(IMG_H));
    end

    // Read-slot address register plus slot/valid tags that track the ZBT latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= 19'd0;
            rd_pipe_r  <= {(LATENCY + 1){1'b0}};
            vld_pipe_r <= {(LATENCY + 1){1'b0}};
        end else begin
            if (hcount[0]) begin
                addr_r <= {1'b0, t_row_s, t_col_s[8:1]};
            end
            rd_pipe_r  <= {rd_pipe_r[LATENCY-1:0], hcount[0]};
            vld_pipe_r <= {vld_pipe_r[LATENCY-1:0], hcount[0] & t_valid_s};
        end
    end

    // Capture the returning pixel pair when its read slot reaches the end of the latency pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r     <= 36'd0;
            word_vld_r <= 1'b0;
        end else if (rd_pipe_r[LATENCY]) begin
            word_r     <= vram_read_data;
            word_vld_r <= vld_pipe_r[LATENCY];
        end else begin
            word_r     <= word_r;
            word_vld_r <= word_vld_r;
        end
    end

    // First stage of the raster delay line: pixel parity and sync/blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc0_d1_r   <= 1'b0;
            hsync_d1_r <= 1'b1;
            vsync_d1_r <= 1'b1;
            blank_d1_r <= 1'b1;
        end else begin
            hc0_d1_r   <= hcount[0];
            hsync_d1_r <= hsync;
            vsync_d1_r <= vsync;
            blank_d1_r <= blank;
        end
    end

    // Pick the even/odd half of the pair and expand it, or force black.
    always_comb begin
        pix_sel_s  = 18'd0;
        pix_next_s = 24'd0;
        if (hc0_d1_r) begin
            pix_sel_s = word_r[17:0];
        end else begin
            pix_sel_s = word_r[35:18];
        end
        if (word_vld_r && !blank_d1_r) begin
            pix_next_s = rgb666_to_888(pix_sel_s);
        end else begin
            pix_next_s = 24'd0;
        end
    end

    // Output stage: pixel and sync/blank leave together two cycles after the raster.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_r <= 24'd0;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            blank_r <= 1'b1;
        end else begin
            pixel_r <= pix_next_s;
            hsync_r <= hsync_d1_r;
            vsync_r <= vsync_d1_r;
            blank_r <= blank_d1_r;
        end
    end

    // The write slot must coincide with the even-hcount cycle itself, so this one is not registered.
    assign vram_write_ok = ~reset & ~hcount[0];
    assign vram_addr     = addr_r;
    assign pixel_rgb     = pixel_r;
    assign hsync_out     = hsync_r;
    assign vsync_out     = vsync_r;
    assign blank_out     = blank_r;

endmodule
